// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the conv and maxpool forward-pass blocks.
//   DEFAULT_DATA_WIDTH : default element width (signed two's complement)
//   pool_state_e       : maxpool FSM states (IDLE, SCAN, DONE)
//   conv_out_dim()     : output dimension for an input size, kernel/window,
//                        stride and padding (floor division)
package conv_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } pool_state_e;

  function automatic int unsigned conv_out_dim(input int unsigned in_dim,
                                               input int unsigned k,
                                               input int unsigned stride,
                                               input int unsigned pad);
    return (in_dim + 2 * pad - k) / stride + 1;
  endfunction

endpackage

// File: rtl/maxpool_forward_pass_if.sv
// maxpool_forward_pass_if: request/result bundle of the maxpool stage.
//   start              : request, sampled by the pool only while idle
//   input_tensor_flat  : conv output tensor, channel-major (IN_BITS wide)
//   busy               : scan in progress
//   done               : one-cycle completion pulse
//   output_tensor_flat : pooled tensor, channel-major (OUT_BITS wide)
// master = requester (conv side / bench), slave = the pooling stage.
interface maxpool_forward_pass_if #(
  parameter int unsigned IN_BITS  = 128,
  parameter int unsigned OUT_BITS = 32
);
  logic                start;
  logic [IN_BITS-1:0]  input_tensor_flat;
  logic                busy;
  logic                done;
  logic [OUT_BITS-1:0] output_tensor_flat;

  modport master (
    output start,
    output input_tensor_flat,
    input  busy,
    input  done,
    input  output_tensor_flat
  );

  modport slave (
    input  start,
    input  input_tensor_flat,
    output busy,
    output done,
    output output_tensor_flat
  );
endinterface

// File: rtl/pool_window_addr.sv
// pool_window_addr: counter nest c > oy > ox > ky > kx for the pooling scan.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : zero all counters (takes priority over advance)
//   advance         : step kx by one, carrying outwards
//   in_idx          : flat input element index of (c, oy*S+ky, ox*S+kx)
//   out_idx         : flat output element index of (c, oy, ox)
//   first_in_window : (ky,kx) == (0,0)
//   last_in_window  : (ky,kx) == (P-1,P-1)
//   last_overall    : last element of the last window of the last channel
module pool_window_addr #(
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned IN_HEIGHT  = 2,
  parameter int unsigned IN_WIDTH   = 2,
  parameter int unsigned POOL_SIZE  = 2,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned OUT_HEIGHT = 1,
  parameter int unsigned OUT_WIDTH  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  output logic [31:0] in_idx,
  output logic [31:0] out_idx,
  output logic        first_in_window,
  output logic        last_in_window,
  output logic        last_overall
);

  logic [31:0] c_q, c_d, oy_q, oy_d, ox_q, ox_d, ky_q, ky_d, kx_q, kx_d;

  always_comb begin
    c_d  = c_q;
    oy_d = oy_q;
    ox_d = ox_q;
    ky_d = ky_q;
    kx_d = kx_q;
    if (clear) begin
      c_d  = '0;
      oy_d = '0;
      ox_d = '0;
      ky_d = '0;
      kx_d = '0;
    end else if (advance) begin
      if (kx_q == POOL_SIZE - 1) begin
        kx_d = '0;
        if (ky_q == POOL_SIZE - 1) begin
          ky_d = '0;
          if (ox_q == OUT_WIDTH - 1) begin
            ox_d = '0;
            if (oy_q == OUT_HEIGHT - 1) begin
              oy_d = '0;
              c_d  = (c_q == CHANNELS - 1) ? '0 : c_q + 1;
            end else begin
              oy_d = oy_q + 1;
            end
          end else begin
            ox_d = ox_q + 1;
          end
        end else begin
          ky_d = ky_q + 1;
        end
      end else begin
        kx_d = kx_q + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q  <= '0;
      oy_q <= '0;
      ox_q <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else begin
      c_q  <= c_d;
      oy_q <= oy_d;
      ox_q <= ox_d;
      ky_q <= ky_d;
      kx_q <= kx_d;
    end
  end

  assign in_idx  = (c_q * IN_HEIGHT + oy_q * STRIDE + ky_q) * IN_WIDTH
                 + ox_q * STRIDE + kx_q;
  assign out_idx = (c_q * OUT_HEIGHT + oy_q) * OUT_WIDTH + ox_q;

  assign first_in_window = (kx_q == '0) && (ky_q == '0);
  assign last_in_window  = (kx_q == POOL_SIZE - 1) && (ky_q == POOL_SIZE - 1);
  assign last_overall    = last_in_window && (ox_q == OUT_WIDTH - 1) &&
                           (oy_q == OUT_HEIGHT - 1) && (c_q == CHANNELS - 1);

endmodule

// File: rtl/maxpool_forward_pass.sv
// maxpool_forward_pass: sequential max-pooling stage behind conv_forward_pass.
// Snapshots the input tensor on an accepted start, scans one window element
// per cycle, then publishes the pooled tensor together with a done pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : maxpool_forward_pass_if.slave (start, input_tensor_flat,
//              busy, done, output_tensor_flat)
// Optional: define MAXPOOL_RELU_EN to clamp negative window maxima to 0 as
// they are written into the working result.
module maxpool_forward_pass
  import conv_pkg::*;
#(
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned IN_HEIGHT  = 2,
  parameter int unsigned IN_WIDTH   = 2,
  parameter int unsigned POOL_SIZE  = 2,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned OUT_HEIGHT = conv_out_dim(IN_HEIGHT, POOL_SIZE, STRIDE, 0),
  parameter int unsigned OUT_WIDTH  = conv_out_dim(IN_WIDTH, POOL_SIZE, STRIDE, 0),
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  maxpool_forward_pass_if.slave  bus
);

  localparam int unsigned IN_BITS  = CHANNELS * IN_HEIGHT * IN_WIDTH * DATA_WIDTH;
  localparam int unsigned OUT_BITS = CHANNELS * OUT_HEIGHT * OUT_WIDTH * DATA_WIDTH;

  pool_state_e                  state_q, state_d;
  logic [IN_BITS-1:0]           snap_q, snap_d;
  logic [OUT_BITS-1:0]          work_q, work_d;
  logic [OUT_BITS-1:0]          out_q, out_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic signed [DATA_WIDTH-1:0] elem, cand, wr_val;

  logic [31:0] in_idx, out_idx;
  logic        first_in_window, last_in_window, last_overall;
  logic        clear, advance;

  pool_window_addr #(
    .CHANNELS   (CHANNELS),
    .IN_HEIGHT  (IN_HEIGHT),
    .IN_WIDTH   (IN_WIDTH),
    .POOL_SIZE  (POOL_SIZE),
    .STRIDE     (STRIDE),
    .OUT_HEIGHT (OUT_HEIGHT),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_addr (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .advance         (advance),
    .in_idx          (in_idx),
    .out_idx         (out_idx),
    .first_in_window (first_in_window),
    .last_in_window  (last_in_window),
    .last_overall    (last_overall)
  );

  assign elem = snap_q[in_idx*DATA_WIDTH +: DATA_WIDTH];

  // Window maximum including the current element; the first element of a
  // window restarts it, later ones only win when strictly greater so ties
  // keep the earlier value.
  assign cand = (first_in_window || (elem > max_q)) ? elem : max_q;

`ifdef MAXPOOL_RELU_EN
  assign wr_val = cand[DATA_WIDTH-1] ? '0 : cand;
`else
  assign wr_val = cand;
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    work_d  = work_q;
    out_d   = out_q;
    max_d   = max_q;
    clear   = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d  = bus.input_tensor_flat;
          clear   = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        advance = 1'b1;
        max_d   = cand;
        if (last_in_window) begin
          work_d[out_idx*DATA_WIDTH +: DATA_WIDTH] = wr_val;
        end
        // Publish from work_d so the final window written this cycle is
        // included in the visible result.
        if (last_overall) begin
          out_d   = work_d;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      work_q  <= '0;
      out_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      work_q  <= work_d;
      out_q   <= out_d;
      max_q   <= max_d;
    end
  end

  assign bus.busy               = (state_q == SCAN);
  assign bus.done               = (state_q == DONE);
  assign bus.output_tensor_flat = out_q;

endmodule

// File: doc/maxpool_forward_pass.md
# maxpool_forward_pass

Sequential max-pooling stage that sits directly downstream of `conv_forward_pass`. It captures that block's flat output tensor on a start pulse and scans every pooling window one element per cycle. It then presents the pooled tensor on a flat output bus with a one-cycle `done` pulse. Tensor layout is channel-major on both sides: element (c,y,x) occupies bits `[((c*H + y)*W + x)*DATA_WIDTH +: DATA_WIDTH]`.

## Interface
- `CHANNELS`, 1: number of channels; equals the conv block's OUT_CHANNELS.
- `IN_HEIGHT`, 2: input rows; equals the conv block's OUT_HEIGHT.
- `IN_WIDTH`, 2: input columns; equals the conv block's OUT_WIDTH.
- `POOL_SIZE`, 2: square window edge, ≥1, ≤ IN_HEIGHT and IN_WIDTH.
- `STRIDE`, 2: window step, ≥1.
- `OUT_HEIGHT`, (IN_HEIGHT-POOL_SIZE)/STRIDE+1: output rows, floor division.
- `OUT_WIDTH`, (IN_WIDTH-POOL_SIZE)/STRIDE+1: output columns, floor division.
- `DATA_WIDTH`, 32: element width, signed two's complement.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `input_tensor_flat`  in  CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH  conv output tensor; sampled on the edge that accepts `start`.
- `busy`  out  1  high while the scan is in progress.
- `done`  out  1  one-cycle completion pulse.
- `output_tensor_flat`  out  CHANNELS*OUT_HEIGHT*OUT_WIDTH*DATA_WIDTH  pooled tensor; no padding.

## Operation
- States:
  - IDLE → SCAN when `start`=1. On that edge, `input_tensor_flat` is copied into an internal snapshot and all counters are cleared.
  - SCAN → DONE after the last element of the last window.
  - DONE → IDLE unconditionally.
- Counter nest, outermost first: c, oy, ox, ky, kx. kx increments each SCAN cycle. Each counter wraps at its limit and carries into the next one out.
- Element address: y = oy*STRIDE+ky, x = ox*STRIDE+kx. Rows and columns beyond the last full window are never read.
- Running max:
  - Loaded with the element at (ky,kx)=(0,0).
  - For later elements, the running max is replaced when the element is strictly greater (signed compare).
  - In the cycle of (ky,kx)=(P-1,P-1), max(running, element) is written to working-result slot (c,oy,ox).
- On SCAN→DONE, the working result is copied to `output_tensor_flat`. The output is therefore stable and holds the previous result for the whole scan.
- Ties keep the earlier value. Bit patterns are identical either way.
- `start` in SCAN or DONE is ignored; it is not queued. Input changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `output_tensor_flat`=0, counters, snapshot and working register all 0.
- Let N = CHANNELS*OUT_HEIGHT*OUT_WIDTH*POOL_SIZE².
- With `start` accepted at edge T0:
  - `busy`=1 for cycles T0+1 through T0+N.
  - `done`=1 and the new output are valid from T0+N+1 for exactly one cycle, with `busy`=0.
  - A new `start` is accepted at the earliest at edge T0+N+2.
- `rst` asserted mid-scan aborts on that edge: outputs return to reset values and no `done` pulse is produced.
- `rst` and `start` high together: reset wins.
- POOL_SIZE=1: one cycle per output element. The block acts as a pass-through/subsampler with STRIDE.

## Configuration
- `MAXPOOL_RELU_EN` defined: each value written to the working result is clamped to 0 when negative (fused ReLU). The clamp is applied at the write only.
- Not defined: signed maxima are passed unchanged.

## Structure
- Shared package `conv_pkg`:
  - `DATA_WIDTH` default.
  - Pool FSM state enum (IDLE, SCAN, DONE).
  - Output-dimension helper function `conv_out_dim(in, k, stride, pad)`, also used by the conv block.
- Sub-module `pool_window_addr`: the counter nest and flat index generation, with `last_in_window` and `last_overall` flags.
- Top level holds the snapshot, the running max, the result registers and the FSM.

## Test plan
- CHANNELS=1, 4x4 input 1..16 (row-major), POOL=2, STRIDE=2, start at T0 → `done` at T0+17, output [6,8,14,16], `busy` high for exactly 16 cycles.
- CHANNELS=2, channel 0 = 1..16, channel 1 = 101..116 → output [6,8,14,16,106,108,114,116], `done` at T0+33.
- 3x3 input 1..9, POOL=2, STRIDE=1 → [5,6,8,9]. 5x5 input, POOL=2, STRIDE=2 → row 4 and column 4 are never read; result 2x2.
- Window {-5,-3,-7,-9} → -3 without `MAXPOOL_RELU_EN`, 0 with it.
- Pulse `start` again mid-scan with new input → ignored; the result matches the first input and only one `done` pulse occurs.
- Assert `rst` at T0+5 → `busy`/`done`/output go to 0 on the next edge. A fresh `start` then completes normally.
